// File: rtl/mac_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_pkg: shared widths, fflags bit positions and result-stage entry type.
// Rev 1.0
// ----------------------------------------------------------------------------
package mac_pkg;

  localparam int PARM_EXP  = 8;
  localparam int PARM_MANT = 23;
  localparam int PARM_TAG  = 5;
  localparam logic [PARM_EXP+PARM_MANT:0] PARM_CANON_NAN = 32'h7FC0_0000;

  localparam int FFLAGS_W = 5;
  localparam int FF_NV    = 4;
  localparam int FF_DZ    = 3;
  localparam int FF_OF    = 2;
  localparam int FF_UF    = 1;
  localparam int FF_NX    = 0;

  typedef struct packed {
    logic [PARM_EXP+PARM_MANT:0] result;
    logic [PARM_TAG-1:0]         tag;
    logic [FFLAGS_W-1:0]         fflags;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/mac_skid_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_skid_buf: 2-entry valid/ready skid buffer with a registered ready.
// Rev 1.0
// ----------------------------------------------------------------------------
module mac_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             Clk_i,
  input  logic             Rst_ni,
  input  logic             In_valid_i,
  output logic             In_ready_o,
  input  logic [WIDTH-1:0] In_data_i,
  output logic             Out_valid_o,
  input  logic             Out_ready_i,
  output logic [WIDTH-1:0] Out_data_o
);

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic             ready_q;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             w_accept;
  logic             w_commit;

  assign w_accept = In_valid_i && ready_q;
  assign w_commit = m_valid_q && Out_ready_i;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (!m_valid_q || w_commit) begin
      // A full skid slot always refills main first; ready was low so no accept competes.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = w_accept;
        if (w_accept) begin
          m_data_d = In_data_i;
        end
      end
    end else if (w_accept) begin
      s_valid_d = 1'b1;
      s_data_d  = In_data_i;
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= !s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign In_ready_o  = ready_q;
  assign Out_valid_o = m_valid_q;
  assign Out_data_o  = m_data_q;

endmodule
`default_nettype wire

// File: rtl/mac_result_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_result_stage: packs/canonicalises rounder results, buffers them, accrues fflags.
// Rev 1.0
// ----------------------------------------------------------------------------
module mac_result_stage
  import mac_pkg::entry_t, mac_pkg::FFLAGS_W, mac_pkg::FF_NV, mac_pkg::FF_DZ,
         mac_pkg::FF_OF, mac_pkg::FF_UF, mac_pkg::FF_NX;
#(
  parameter int                          PARM_EXP       = mac_pkg::PARM_EXP,
  parameter int                          PARM_MANT      = mac_pkg::PARM_MANT,
  parameter int                          PARM_TAG       = mac_pkg::PARM_TAG,
  parameter logic [PARM_EXP+PARM_MANT:0] PARM_CANON_NAN = mac_pkg::PARM_CANON_NAN
) (
  input  logic                          Clk_i,
  input  logic                          Rst_ni,
  input  logic                          In_valid_i,
  output logic                          In_ready_o,
  input  logic                          Sign_i,
  input  logic [PARM_EXP-1:0]           Exp_i,
  input  logic [PARM_MANT-1:0]          Mant_i,
  input  logic [PARM_TAG-1:0]           Tag_i,
  input  logic                          Invalid_i,
  input  logic                          Overflow_i,
  input  logic                          Underflow_i,
  input  logic                          Inexact_i,
  output logic                          Out_valid_o,
  input  logic                          Out_ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [PARM_TAG-1:0]           Tag_o,
  output logic [4:0]                    Fflags_o,
  output logic [4:0]                    Fflags_acc_o,
  input  logic                          Fflags_clr_i,
  input  logic                          Fflags_wr_i,
  input  logic [4:0]                    Fflags_wdata_i
);

  localparam int ENTRY_W = $bits(entry_t);

  logic                        w_is_nan;
  logic [FFLAGS_W-1:0]         w_flags;
  logic [FFLAGS_W-1:0]         w_commit_flags;
  logic                        w_commit;
  entry_t                      w_in_entry;
  entry_t                      w_out_entry;
  logic [FFLAGS_W-1:0]         acc_q, acc_d;

  always_comb begin
    w_is_nan          = (&Exp_i) && (|Mant_i);
    w_flags           = '0;
    w_flags[FF_NV]    = Invalid_i;
    w_flags[FF_DZ]    = 1'b0;
    w_flags[FF_OF]    = Overflow_i;
    w_flags[FF_UF]    = Underflow_i;
    w_flags[FF_NX]    = Inexact_i;
    w_in_entry.result = w_is_nan ? PARM_CANON_NAN : {Sign_i, Exp_i, Mant_i};
    w_in_entry.tag    = Tag_i;
    w_in_entry.fflags = w_flags;
  end

  mac_skid_buf #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .Clk_i       (Clk_i),
    .Rst_ni      (Rst_ni),
    .In_valid_i  (In_valid_i),
    .In_ready_o  (In_ready_o),
    .In_data_i   (w_in_entry),
    .Out_valid_o (Out_valid_o),
    .Out_ready_i (Out_ready_i),
    .Out_data_o  (w_out_entry)
  );

  assign Result_o = w_out_entry.result;
  assign Tag_o    = w_out_entry.tag;
  assign Fflags_o = w_out_entry.fflags;

  // Flags only accrue once writeback takes the result; clear beats write beats hold.
  assign w_commit       = Out_valid_o && Out_ready_i;
  assign w_commit_flags = w_commit ? w_out_entry.fflags : '0;

  always_comb begin
    acc_d = acc_q | w_commit_flags;
    if (Fflags_clr_i) begin
      acc_d = '0;
    end else if (Fflags_wr_i) begin
      acc_d = Fflags_wdata_i | w_commit_flags;
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign Fflags_acc_o = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mac_result_stage: directed scenarios plus a randomized scoreboard run.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mac_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        sign = 1'b0;
  logic [7:0]  expo = '0;
  logic [22:0] mant = '0;
  logic [4:0]  tag = '0;
  logic        nv = 1'b0, of = 1'b0, uf = 1'b0, nx = 1'b0;
  logic        out_ready = 1'b0;
  logic        fclr = 1'b0, fwr = 1'b0;
  logic [4:0]  fwdata = '0;

  logic        In_ready_o, Out_valid_o;
  logic [31:0] Result_o;
  logic [4:0]  Tag_o, Fflags_o, Fflags_acc_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_result_stage dut (
    .Clk_i          (clk),
    .Rst_ni         (rst_n),
    .In_valid_i     (in_valid),
    .In_ready_o     (In_ready_o),
    .Sign_i         (sign),
    .Exp_i          (expo),
    .Mant_i         (mant),
    .Tag_i          (tag),
    .Invalid_i      (nv),
    .Overflow_i     (of),
    .Underflow_i    (uf),
    .Inexact_i      (nx),
    .Out_valid_o    (Out_valid_o),
    .Out_ready_i    (out_ready),
    .Result_o       (Result_o),
    .Tag_o          (Tag_o),
    .Fflags_o       (Fflags_o),
    .Fflags_acc_o   (Fflags_acc_o),
    .Fflags_clr_i   (fclr),
    .Fflags_wr_i    (fwr),
    .Fflags_wdata_i (fwdata)
  );

  function automatic logic [31:0] ref_pack(input logic s, input logic [7:0] e, input logic [22:0] m);
    if (e == 8'hFF && m != 23'd0) return 32'h7FC0_0000;
    return {s, e, m};
  endfunction

  task automatic set_in(input logic v, input logic s, input logic [7:0] e, input logic [22:0] m,
                        input logic [4:0] tg, input logic f_nv, input logic f_of,
                        input logic f_uf, input logic f_nx);
    in_valid = v; sign = s; expo = e; mant = m; tag = tg;
    nv = f_nv; of = f_of; uf = f_uf; nx = f_nx;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    set_in(0, 0, 8'h00, 23'd0, 5'd0, 0, 0, 0, 0);
    out_ready = 1'b0; fclr = 1'b0; fwr = 1'b0; fwdata = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (Out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", Out_valid_o); end
    n_tests++; if (In_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", In_ready_o); end
    n_tests++; if (Result_o !== 32'h0 || Tag_o !== 5'h0) begin n_fail++; $display("FAIL reset_data: got result %h tag %h expected 0/0", Result_o, Tag_o); end
    n_tests++; if (Fflags_o !== 5'h0 || Fflags_acc_o !== 5'h0) begin n_fail++; $display("FAIL reset_flags: got %b/%b expected 0/0", Fflags_o, Fflags_acc_o); end
    do_reset();
  endtask

  task automatic test_basic;
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1; set_in(1, 0, 8'h7F, 23'd0, 5'd7, 0, 0, 0, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    n_tests++; if (Out_valid_o !== 1'b1 || Result_o !== 32'h3F80_0000) begin n_fail++; $display("FAIL basic_result: got v=%b %h expected v=1 3f800000", Out_valid_o, Result_o); end
    n_tests++; if (Fflags_o !== 5'b00001 || Tag_o !== 5'd7) begin n_fail++; $display("FAIL basic_flags_tag: got %b tag %0d expected 00001 tag 7", Fflags_o, Tag_o); end
    n_tests++; if (Fflags_acc_o !== 5'b00000) begin n_fail++; $display("FAIL basic_acc_before_commit: got %b expected 00000", Fflags_acc_o); end
    @(posedge clk); #1;
    n_tests++; if (Fflags_acc_o !== 5'b00001) begin n_fail++; $display("FAIL basic_acc_after_commit: got %b expected 00001", Fflags_acc_o); end
    n_tests++; if (Out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b expected 0", Out_valid_o); end
  endtask

  task automatic test_nan;
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1; set_in(1, 1, 8'hFF, 23'h000001, 5'd2, 1, 0, 0, 0);
    @(posedge clk); #1; set_in(1, 1, 8'hFF, 23'h000000, 5'd3, 0, 0, 0, 0);
    n_tests++; if (Result_o !== 32'h7FC0_0000) begin n_fail++; $display("FAIL nan_canon: got %h expected 7fc00000", Result_o); end
    n_tests++; if (Fflags_o !== 5'b10000) begin n_fail++; $display("FAIL nan_flags: got %b expected 10000", Fflags_o); end
    @(posedge clk); #1; in_valid = 1'b0;
    n_tests++; if (Out_valid_o !== 1'b1 || Result_o !== 32'hFF80_0000 || Tag_o !== 5'd3) begin n_fail++; $display("FAIL inf_pass: got v=%b %h tag %0d expected v=1 ff800000 tag 3", Out_valid_o, Result_o, Tag_o); end
  endtask

  task automatic test_back_to_back;
    logic [4:0] got[$];
    logic       acc_now;
    int         acc_cyc;
    do_reset();
    out_ready = 1'b0;
    acc_cyc = -1;
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk); #1; set_in(1, 0, 8'h40, 23'(t), 5'(t), 0, 0, 0, 0);
      @(negedge clk);
      n_tests++; if (In_ready_o !== (t < 3)) begin n_fail++; $display("FAIL b2b_ready_fill%0d: got %b expected %b", t, In_ready_o, (t < 3)); end
    end
    @(posedge clk); #1;
    n_tests++; if (In_ready_o !== 1'b0 || Out_valid_o !== 1'b1 || Tag_o !== 5'd1) begin n_fail++; $display("FAIL b2b_hold: got rdy=%b v=%b tag %0d expected 0/1/1", In_ready_o, Out_valid_o, Tag_o); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (Out_valid_o && out_ready) got.push_back(Tag_o);
      acc_now = in_valid && In_ready_o;
      if (acc_now) acc_cyc = c;
      @(posedge clk); #1;
      if (acc_now) in_valid = 1'b0;
    end
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_tests++; if (got[i] !== 5'(i + 1)) begin n_fail++; $display("FAIL b2b_order%0d: got tag %0d expected %0d", i, got[i], i + 1); end
    end
    n_tests++; if (acc_cyc != 1) begin n_fail++; $display("FAIL b2b_third_accept: got cycle %0d expected 1", acc_cyc); end
  endtask

  task automatic test_acc;
    do_reset();
    out_ready = 1'b0;
    @(posedge clk); #1; set_in(1, 0, 8'h80, 23'h123, 5'd9, 0, 1, 0, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    n_tests++; if (Fflags_o !== 5'b00101) begin n_fail++; $display("FAIL acc_opflags: got %b expected 00101", Fflags_o); end
    out_ready = 1'b1; fwr = 1'b1; fwdata = 5'b00010;
    @(posedge clk); #1; out_ready = 1'b0; fwr = 1'b0;
    n_tests++; if (Fflags_acc_o !== 5'b00111) begin n_fail++; $display("FAIL acc_write_commit: got %b expected 00111", Fflags_acc_o); end
    fwr = 1'b1; fwdata = 5'b01000;
    @(posedge clk); #1; fwr = 1'b0;
    n_tests++; if (Fflags_acc_o !== 5'b01000) begin n_fail++; $display("FAIL acc_write_only: got %b expected 01000", Fflags_acc_o); end
    set_in(1, 0, 8'h80, 23'h55, 5'd10, 0, 1, 0, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    n_tests++; if (Fflags_acc_o !== 5'b01000) begin n_fail++; $display("FAIL acc_no_accrue_on_accept: got %b expected 01000", Fflags_acc_o); end
    out_ready = 1'b1; fclr = 1'b1; fwr = 1'b1; fwdata = 5'b11111;
    @(posedge clk); #1; out_ready = 1'b0; fclr = 1'b0; fwr = 1'b0;
    n_tests++; if (Fflags_acc_o !== 5'b00000) begin n_fail++; $display("FAIL acc_clear_wins: got %b expected 00000", Fflags_acc_o); end
  endtask

  task automatic test_async_reset;
    do_reset();
    out_ready = 1'b0;
    @(posedge clk); #1; set_in(1, 0, 8'h10, 23'd1, 5'd1, 1, 0, 0, 0);
    @(posedge clk); #1; set_in(1, 0, 8'h11, 23'd2, 5'd2, 0, 0, 1, 0);
    @(posedge clk); #1; in_valid = 1'b0; fwr = 1'b1; fwdata = 5'b10101;
    @(posedge clk); #1; fwr = 1'b0;
    n_tests++; if (Out_valid_o !== 1'b1 || In_ready_o !== 1'b0 || Fflags_acc_o !== 5'b10101) begin n_fail++; $display("FAIL arst_prefill: got v=%b rdy=%b acc=%b expected 1/0/10101", Out_valid_o, In_ready_o, Fflags_acc_o); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (Out_valid_o !== 1'b0 || Fflags_acc_o !== 5'b00000 || Result_o !== 32'h0) begin n_fail++; $display("FAIL arst_immediate: got v=%b acc=%b res=%h expected 0/00000/0", Out_valid_o, Fflags_acc_o, Result_o); end
    out_ready = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (In_ready_o !== 1'b1 || Out_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_release: got rdy=%b v=%b expected 1/0", In_ready_o, Out_valid_o); end
    @(posedge clk); #1;
    n_tests++; if (Out_valid_o !== 1'b0 || Fflags_acc_o !== 5'b00000) begin n_fail++; $display("FAIL arst_flushed: got v=%b acc=%b expected 0/00000", Out_valid_o, Fflags_acc_o); end
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] q_res[$];
    logic [4:0]  q_tag[$];
    logic [4:0]  q_ff[$];
    logic [4:0]  acc_model;
    logic [4:0]  commit_ff;
    logic        do_commit;
    int accepted, committed, cyc;
    do_reset();
    acc_model = '0; accepted = 0; committed = 0; cyc = 0;
    while (committed < 1000 && cyc < 20000) begin
      if (accepted < 1000) begin
        set_in((cyc < 200) ? 1'b1 : ($urandom_range(0, 9) < 7), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
               ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc < 200) ? 1'b1 : ($urandom_range(0, 9) < 6);
      fclr = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      n_tests++; if (Out_valid_o !== (q_res.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, Out_valid_o, (q_res.size() > 0)); end
      n_tests++; if (In_ready_o !== (q_res.size() < 2)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", cyc, In_ready_o, (q_res.size() < 2)); end
      n_tests++; if (Fflags_acc_o !== acc_model) begin n_fail++; $display("FAIL rnd_acc c%0d: got %b expected %b", cyc, Fflags_acc_o, acc_model); end
      do_commit = Out_valid_o && out_ready && (q_res.size() > 0);
      commit_ff = '0;
      if (do_commit) begin
        n_tests++;
        if (Result_o !== q_res[0] || Tag_o !== q_tag[0] || Fflags_o !== q_ff[0]) begin
          n_fail++;
          $display("FAIL rnd_data c%0d: got %h/%0d/%b expected %h/%0d/%b", cyc, Result_o, Tag_o, Fflags_o, q_res[0], q_tag[0], q_ff[0]);
        end
        commit_ff = q_ff[0];
        void'(q_res.pop_front()); void'(q_tag.pop_front()); void'(q_ff.pop_front());
        committed++;
      end
      if (in_valid && In_ready_o) begin
        q_res.push_back(ref_pack(sign, expo, mant));
        q_tag.push_back(tag);
        q_ff.push_back({nv, 1'b0, of, uf, nx});
        accepted++;
      end
      acc_model = fclr ? 5'b00000 : (acc_model | commit_ff);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; fclr = 1'b0;
    n_tests++; if (committed != 1000) begin n_fail++; $display("FAIL rnd_complete: got %0d committed expected 1000", committed); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nan();
    test_back_to_back();
    test_acc();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_result_stage.md
Name: mac_result_stage

Overview:
Output stage directly downstream of the MAC rounder. Captures the rounder's combinational sign/exponent/mantissa and exception flags into a valid/ready pipeline with a 2-entry skid buffer. Packs the fields into an IEEE-754 binary32 word and canonicalises NaNs. Maintains the accrued RISC-V fflags register (NV DZ OF UF NX) that the CSR unit reads, writes and clears.

Parameters:
PARM_EXP, 8, exponent width
PARM_MANT, 23, stored mantissa width
PARM_TAG, 5, destination-register tag width
PARM_CANON_NAN, 32'h7FC0_0000, canonical quiet NaN

Ports:
Clk_i  in  1  clock, rising edge
Rst_ni  in  1  asynchronous active-low reset
In_valid_i  in  1  rounder result valid
In_ready_o  out  1  stage can accept a result
Sign_i  in  1  rounder sign
Exp_i  in  PARM_EXP  rounder exponent
Mant_i  in  PARM_MANT  rounder mantissa
Tag_i  in  PARM_TAG  destination tag travelling with the result
Invalid_i  in  1  rounder invalid flag
Overflow_i  in  1  rounder overflow flag
Underflow_i  in  1  rounder underflow flag
Inexact_i  in  1  rounder inexact flag
Out_valid_o  out  1  result valid to writeback
Out_ready_i  in  1  writeback accepts result
Result_o  out  1+PARM_EXP+PARM_MANT  packed float {sign, exp, mant}
Tag_o  out  PARM_TAG  tag of the presented result
Fflags_o  out  5  per-op flags {NV,DZ,OF,UF,NX}
Fflags_acc_o  out  5  accrued fflags
Fflags_clr_i  in  1  clear accrued flags
Fflags_wr_i  in  1  CSR write of accrued flags
Fflags_wdata_i  in  5  CSR write data

Behaviour:
- Reset (Rst_ni low, asynchronous): both buffer entries invalid; Out_valid_o=0; In_ready_o=1; Result_o=0; Tag_o=0; Fflags_o=0; Fflags_acc_o=0. Reset asserted mid-transfer discards all buffered results.
- Input accept: occurs when In_valid_i && In_ready_o at a rising edge.
- Output commit: occurs when Out_valid_o && Out_ready_i at a rising edge.
- Latency: a result accepted at edge N is presented from N+1 when the main entry is free. No combinational path from In_* to Out_*.
- Buffer: main entry M drives the outputs; skid entry S.
  - Accept with M empty, or with M committing the same cycle: write M.
  - Accept while M is held (valid, not committing): write S.
  - Commit with S full: S moves to M.
- In_ready_o is a registered signal equal to !S.valid. It never depends combinationally on Out_ready_i. With S full, In_ready_o=0 and no data is lost.
- Ordering: strict FIFO; a result is never dropped or duplicated.
- Packing at capture: packed = {Sign_i, Exp_i, Mant_i}.
- NaN canonicalisation: if Exp_i is all ones and Mant_i != 0, store PARM_CANON_NAN (sign forced to 0). Infinities (Exp_i all ones, Mant_i = 0) pass unchanged.
- Per-op flags: Fflags = {Invalid_i, 1'b0, Overflow_i, Underflow_i, Inexact_i}. DZ is always 0 (the MAC cannot divide). The flags are stored with the entry and presented on Fflags_o together with the result.
- Accrued flags, next value each edge:
  - Fflags_clr_i: 0. Clear wins over write and over commit.
  - else Fflags_wr_i: Fflags_wdata_i OR (commit ? Fflags_o : 0).
  - else: Fflags_acc_o OR (commit ? Fflags_o : 0).
  - Flags accrue at commit only, not at accept. Held or reset-flushed results contribute nothing.
- Out_valid_o, Result_o, Tag_o and Fflags_o stay stable while Out_valid_o=1 and Out_ready_i=0.
- Throughput: 1 result/cycle while Out_ready_i=1.

Decomposition:
- Shared package mac_pkg: PARM_EXP, PARM_MANT, PARM_CANON_NAN, fflags bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0), and a packed entry struct {result, tag, fflags}.
- One sub-module, mac_skid_buf: generic 2-entry valid/ready skid buffer parameterised on payload width.
- Packing/canonicalisation and the fflags accumulator live in the top module.

Test Plan:
- Reset then one input {Sign=0, Exp=8'h7F, Mant=0, Inexact=1}, Out_ready_i=1 -> next cycle Result_o=32'h3F80_0000, Fflags_o=5'b00001; Fflags_acc_o=5'b00001 after commit.
- Input Exp=8'hFF, Mant=23'h000001, Sign=1, Invalid=1 -> Result_o=32'h7FC0_0000, Fflags_o=5'b10000; Exp=8'hFF, Mant=0, Sign=1 -> 32'hFF80_0000 unchanged.
- Out_ready_i=0 while 3 results are offered back to back -> M and S fill, In_ready_o=0 on cycle 3. Release Out_ready_i -> results exit in order with tags 1,2,3; third accepted only after In_ready_o returns to 1.
- Overflow+Inexact result committing in the same cycle as Fflags_wr_i=1, wdata=5'b00010 -> Fflags_acc_o=5'b00111. Same cycle with Fflags_clr_i=1 -> Fflags_acc_o=0.
- Rst_ni pulsed low asynchronously with both entries full -> Out_valid_o=0 immediately, Fflags_acc_o=0, In_ready_o=1 after release.
- Random valid/ready stream of 1000 results against a scoreboard -> zero loss/duplication, full throughput when Out_ready_i=1, and accrued flags equal the OR of the committed per-op flags.
